// File: rtl/uart_pkg.sv
// Shared UART constants and the occupancy-width helper used across the receive path.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  // Occupancy must represent 0..depth inclusive, hence one bit beyond the pointer width.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver / register-bank side signals of the receive FIFO.
// Inputs are level or strobe sampled on the rising clock edge; outputs are valid all cycle.
interface uart_rx_fifo_if import uart_pkg::*; #(
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W
) ();

  localparam int CW = count_w(DEPTH);

  logic              i_rx_done;
  logic [DATA_W-1:0] i_rx_data;
  logic              i_pop;
  logic              i_clr_ovr;
  logic [CW-1:0]     i_thresh;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_empty;
  logic              o_full;
  logic [CW-1:0]     o_count;
  logic              o_overrun;
  logic              o_level_irq;

  modport master (
    output i_rx_done, i_rx_data, i_pop, i_clr_ovr, i_thresh,
    input  o_rd_data, o_empty, o_full, o_count, o_overrun, o_level_irq
  );

  modport slave (
    input  i_rx_done, i_rx_data, i_pop, i_clr_ovr, i_thresh,
    output o_rd_data, o_empty, o_full, o_count, o_overrun, o_level_irq
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: synchronous write, asynchronous read by address.
module uart_fifo_mem import uart_pkg::*; #(
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Contents are deliberately left unreset; validity is tracked by the FIFO count.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the APB register bank, with
// done-edge push, strobe pop, occupancy, level interrupt and sticky overrun.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic           pClk,
  input  logic           pReset,
  uart_rx_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic          rx_done_q;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;
  logic          overrun;

  logic push_req;
  logic is_empty;
  logic is_full;
  logic do_push;
  logic do_pop;
  logic ovr_evt;

  assign push_req = bus.i_rx_done & ~rx_done_q;
  assign is_empty = (count == '0);
  assign is_full  = (count == CW'(DEPTH));
  assign do_pop   = bus.i_pop & ~is_empty;
  // A full FIFO still accepts a byte when the same cycle frees a slot.
  assign do_push  = push_req & (~is_full | do_pop);
  assign ovr_evt  = push_req & is_full & ~do_pop;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      rx_done_q <= 1'b0;
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overrun   <= 1'b0;
    end else begin
      rx_done_q <= bus.i_rx_done;
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set has priority so a drop coinciding with a clear is never lost.
      if (ovr_evt)            overrun <= 1'b1;
      else if (bus.i_clr_ovr) overrun <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (pClk),
    .we    (do_push),
    .waddr (wp),
    .wdata (bus.i_rx_data),
    .raddr (rp),
    .rdata (bus.o_rd_data)
  );

  assign bus.o_empty     = is_empty;
  assign bus.o_full      = is_full;
  assign bus.o_count     = count;
  assign bus.o_overrun   = overrun;
  assign bus.o_level_irq = (bus.i_thresh != '0) && (count >= bus.i_thresh);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: each scenario task drives stimulus and checks inline.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int CW     = count_w(DEPTH);

  logic pClk;
  logic pReset;
  int   vectors;
  int   miscompares;

  uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .pClk   (pClk),
    .pReset (pReset),
    .bus    (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] d);
    bus.i_rx_done = 1'b1;
    bus.i_rx_data = d;
    tick();
    bus.i_rx_done = 1'b0;
    tick();
  endtask

  task automatic pop_byte();
    bus.i_pop = 1'b1;
    tick();
    bus.i_pop = 1'b0;
  endtask

  task automatic do_reset();
    pReset = 1'b0;
    tick();
    pReset = 1'b1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.i_thresh = CW'(1);
    #2;
    vectors++;
    if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_count !== '0 ||
        bus.o_overrun !== 1'b0 || bus.o_level_irq !== 1'b0) begin
      $display("FAIL reset_state: empty=%b full=%b count=%0d ovr=%b irq=%b, need 1 0 0 0 0",
               bus.o_empty, bus.o_full, bus.o_count, bus.o_overrun, bus.o_level_irq);
      miscompares++;
    end
    pReset = 1'b1;
    tick();
    bus.i_thresh = '0;
  endtask

  task automatic test_hold_done();
    bus.i_rx_done = 1'b1;
    bus.i_rx_data = 8'h41;
    tick();
    vectors++;
    if (bus.o_empty !== 1'b0 || bus.o_count !== CW'(1) || bus.o_rd_data !== 8'h41) begin
      $display("FAIL hold_first_edge: empty=%b count=%0d data=%h, need 0 1 41",
               bus.o_empty, bus.o_count, bus.o_rd_data);
      miscompares++;
    end
    repeat (4) tick();
    vectors++;
    if (bus.o_count !== CW'(1)) begin
      $display("FAIL hold_single_push: count=%0d, need 1", bus.o_count);
      miscompares++;
    end
    bus.i_rx_done = 1'b0;
    tick();
    pop_byte();
  endtask

  task automatic test_full_overrun();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    vectors++;
    if (bus.o_full !== 1'b1 || bus.o_count !== CW'(16) || bus.o_overrun !== 1'b0) begin
      $display("FAIL fill_16: full=%b count=%0d ovr=%b, need 1 16 0",
               bus.o_full, bus.o_count, bus.o_overrun);
      miscompares++;
    end
    push_byte(8'hAA);
    vectors++;
    if (bus.o_full !== 1'b1 || bus.o_count !== CW'(16) || bus.o_overrun !== 1'b1) begin
      $display("FAIL overrun_drop: full=%b count=%0d ovr=%b, need 1 16 1",
               bus.o_full, bus.o_count, bus.o_overrun);
      miscompares++;
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (bus.o_rd_data !== 8'(i)) begin
        $display("FAIL drain_order[%0d]: data=%h, need %h", i, bus.o_rd_data, 8'(i));
        miscompares++;
      end
      pop_byte();
    end
    vectors++;
    if (bus.o_empty !== 1'b1 || bus.o_count !== '0) begin
      $display("FAIL drained_empty: empty=%b count=%0d, need 1 0", bus.o_empty, bus.o_count);
      miscompares++;
    end
    bus.i_clr_ovr = 1'b1;
    tick();
    bus.i_clr_ovr = 1'b0;
    vectors++;
    if (bus.o_overrun !== 1'b0) begin
      $display("FAIL overrun_clear: ovr=%b, need 0", bus.o_overrun);
      miscompares++;
    end
  endtask

  task automatic test_simul_push_pop();
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    bus.i_rx_done = 1'b1;
    bus.i_rx_data = 8'h55;
    bus.i_pop     = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
    bus.i_pop     = 1'b0;
    tick();
    vectors++;
    if (bus.o_overrun !== 1'b0 || bus.o_count !== CW'(16) || bus.o_full !== 1'b1) begin
      $display("FAIL full_push_pop: ovr=%b count=%0d full=%b, need 0 16 1",
               bus.o_overrun, bus.o_count, bus.o_full);
      miscompares++;
    end
    for (int i = 1; i < 16; i++) begin
      vectors++;
      if (bus.o_rd_data !== 8'h10 + 8'(i)) begin
        $display("FAIL full_pp_order[%0d]: data=%h, need %h", i, bus.o_rd_data, 8'h10 + 8'(i));
        miscompares++;
      end
      pop_byte();
    end
    vectors++;
    if (bus.o_rd_data !== 8'h55 || bus.o_count !== CW'(1)) begin
      $display("FAIL full_pp_last: data=%h count=%0d, need 55 1", bus.o_rd_data, bus.o_count);
      miscompares++;
    end
    pop_byte();
    bus.i_rx_done = 1'b1;
    bus.i_rx_data = 8'h33;
    bus.i_pop     = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
    bus.i_pop     = 1'b0;
    tick();
    vectors++;
    if (bus.o_count !== CW'(1) || bus.o_rd_data !== 8'h33) begin
      $display("FAIL empty_push_pop: count=%0d data=%h, need 1 33", bus.o_count, bus.o_rd_data);
      miscompares++;
    end
    pop_byte();
  endtask

  task automatic test_pop_empty_and_wrap();
    pop_byte();
    vectors++;
    if (bus.o_count !== '0 || bus.o_empty !== 1'b1 || bus.o_overrun !== 1'b0) begin
      $display("FAIL pop_empty: count=%0d empty=%b ovr=%b, need 0 1 0",
               bus.o_count, bus.o_empty, bus.o_overrun);
      miscompares++;
    end
    push_byte(8'h77);
    vectors++;
    if (bus.o_rd_data !== 8'h77 || bus.o_count !== CW'(1)) begin
      $display("FAIL push_after_empty_pop: data=%h count=%0d, need 77 1", bus.o_rd_data, bus.o_count);
      miscompares++;
    end
    pop_byte();
    for (int i = 0; i < 40; i++) begin
      push_byte(8'(i));
      vectors++;
      if (bus.o_rd_data !== 8'(i) || bus.o_count !== CW'(1)) begin
        $display("FAIL wrap[%0d]: data=%h count=%0d, need %h 1", i, bus.o_rd_data, bus.o_count, 8'(i));
        miscompares++;
      end
      pop_byte();
    end
  endtask

  task automatic test_level_irq();
    bus.i_thresh = CW'(4);
    for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
    vectors++;
    if (bus.o_level_irq !== 1'b0) begin
      $display("FAIL irq_below: irq=%b, need 0", bus.o_level_irq);
      miscompares++;
    end
    push_byte(8'hC3);
    vectors++;
    if (bus.o_level_irq !== 1'b1) begin
      $display("FAIL irq_at_thresh: irq=%b, need 1", bus.o_level_irq);
      miscompares++;
    end
    pop_byte();
    vectors++;
    if (bus.o_level_irq !== 1'b0) begin
      $display("FAIL irq_after_pop: irq=%b, need 0", bus.o_level_irq);
      miscompares++;
    end
    bus.i_thresh = '0;
    for (int i = 3; i < 16; i++) begin
      push_byte(8'(i));
      vectors++;
      if (bus.o_level_irq !== 1'b0) begin
        $display("FAIL irq_disabled[%0d]: irq=%b, need 0", i, bus.o_level_irq);
        miscompares++;
      end
    end
    bus.i_rx_done = 1'b1;
    bus.i_rx_data = 8'hEE;
    bus.i_clr_ovr = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
    bus.i_clr_ovr = 1'b0;
    vectors++;
    if (bus.o_overrun !== 1'b1 || bus.o_count !== CW'(16)) begin
      $display("FAIL ovr_set_wins: ovr=%b count=%0d, need 1 16", bus.o_overrun, bus.o_count);
      miscompares++;
    end
    tick();
    bus.i_clr_ovr = 1'b1;
    tick();
    bus.i_clr_ovr = 1'b0;
    vectors++;
    if (bus.o_overrun !== 1'b0) begin
      $display("FAIL ovr_clear_alone: ovr=%b, need 0", bus.o_overrun);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 6; i++) push_byte(8'hB0 + 8'(i));
    bus.i_rx_done = 1'b1;
    bus.i_rx_data = 8'h9A;
    pReset = 1'b0;
    #2;
    vectors++;
    if (bus.o_count !== '0 || bus.o_empty !== 1'b1) begin
      $display("FAIL async_reset: count=%0d empty=%b, need 0 1", bus.o_count, bus.o_empty);
      miscompares++;
    end
    tick();
    pReset = 1'b1;
    // First edge after release sees rx_done_q=0, so the held flag counts as one rising edge.
    tick();
    vectors++;
    if (bus.o_count !== CW'(1) || bus.o_rd_data !== 8'h9A) begin
      $display("FAIL release_first_edge: count=%0d data=%h, need 1 9a", bus.o_count, bus.o_rd_data);
      miscompares++;
    end
    repeat (4) tick();
    vectors++;
    if (bus.o_count !== CW'(1)) begin
      $display("FAIL release_held: count=%0d, need 1", bus.o_count);
      miscompares++;
    end
    bus.i_rx_done = 1'b0;
    tick();
    bus.i_rx_data = 8'h9B;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
    vectors++;
    if (bus.o_count !== CW'(2)) begin
      $display("FAIL retoggle_push: count=%0d, need 2", bus.o_count);
      miscompares++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors       = 0;
    miscompares   = 0;
    pReset        = 1'b0;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = '0;
    bus.i_pop     = 1'b0;
    bus.i_clr_ovr = 1'b0;
    bus.i_thresh  = '0;
    test_reset();
    test_hold_done();
    test_full_overrun();
    test_simul_push_pop();
    test_pop_empty_and_wrap();
    test_level_irq();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
